// File: rtl/fetch_prefetch_ctrl_if.sv
// Fetch controller bus: IF-stage control, instruction-memory port and queue-head output.
// master = fetch controller, slave = pipeline/memory side.
interface fetch_prefetch_ctrl_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          fetch_en;
  logic          redirect;
  logic [31:0]   redirect_pc;
  logic [31:0]   mem_addr;
  logic [31:0]   mem_data;
  logic          out_valid;
  logic [31:0]   out_instr;
  logic [31:0]   out_pc;
  logic          out_ready;
  logic [CW-1:0] q_count;

  modport master (
    input  fetch_en, redirect, redirect_pc, mem_data, out_ready,
    output mem_addr, out_valid, out_instr, out_pc, q_count
  );

  modport slave (
    output fetch_en, redirect, redirect_pc, mem_data, out_ready,
    input  mem_addr, out_valid, out_instr, out_pc, q_count
  );
endinterface

// File: rtl/fetch_prefetch_ctrl.sv
// Instruction-fetch controller: owns the fetch PC, reads one word per cycle from a
// combinational memory and buffers {pc, instr} pairs in a DEPTH-entry prefetch queue.
module fetch_prefetch_ctrl #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  fetch_prefetch_ctrl_if.master bus
);
  localparam int          AW           = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C      = DEPTH[AW:0];
  localparam logic [31:0] RESET_PC_ALN = {RESET_PC[31:2], 2'b00};

  logic [31:0]   fetch_pc_reg, fetch_pc_next;
  logic [AW-1:0] rd_ptr_reg,   rd_ptr_next;
  logic [AW-1:0] wr_ptr_reg,   wr_ptr_next;
  logic [AW:0]   count_reg,    count_next;
  logic          enq, deq;
  logic [63:0]   entry_q [DEPTH];

  // Redirect masks out_valid in its own cycle, so deq can never coincide with it.
  assign bus.out_valid = (count_reg != '0) & ~bus.redirect;
  assign deq           = bus.out_valid & bus.out_ready;
  assign enq           = bus.fetch_en & ~bus.redirect & ((count_reg < DEPTH_C) | deq);

  assign bus.mem_addr  = fetch_pc_reg;
  assign bus.q_count   = count_reg;
  assign bus.out_pc    = entry_q[rd_ptr_reg][63:32];
  assign bus.out_instr = entry_q[rd_ptr_reg][31:0];

  // Queue storage is never reset; entries are only visible once count covers them.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [63:0] entry_reg;
      always_ff @(posedge clk) begin
        if (enq && (wr_ptr_reg == AW'(gi))) begin
          entry_reg <= {fetch_pc_reg, bus.mem_data};
        end
      end
      assign entry_q[gi] = entry_reg;
    end
  endgenerate

  always_comb begin
    fetch_pc_next = fetch_pc_reg;
    rd_ptr_next   = rd_ptr_reg;
    wr_ptr_next   = wr_ptr_reg;
    count_next    = count_reg;
    if (bus.redirect) begin
      fetch_pc_next = {bus.redirect_pc[31:2], 2'b00};
      rd_ptr_next   = '0;
      wr_ptr_next   = '0;
      count_next    = '0;
    end else begin
      if (enq) begin
        wr_ptr_next   = wr_ptr_reg + AW'(1);
        fetch_pc_next = fetch_pc_reg + 32'd4;
      end
      if (deq) begin
        rd_ptr_next = rd_ptr_reg + AW'(1);
      end
      case ({enq, deq})
        2'b10:   count_next = count_reg + (AW+1)'(1);
        2'b01:   count_next = count_reg - (AW+1)'(1);
        default: count_next = count_reg;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_reg <= RESET_PC_ALN;
      rd_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
      count_reg    <= '0;
    end else begin
      fetch_pc_reg <= fetch_pc_next;
      rd_ptr_reg   <= rd_ptr_next;
      wr_ptr_reg   <= wr_ptr_next;
      count_reg    <= count_next;
    end
  end
endmodule

// File: tb/tb_fetch_prefetch_ctrl.sv
// Directed bench for fetch_prefetch_ctrl: memory returns instruction = address,
// table of per-cycle vectors plus a hand sequence for asynchronous mid-stream reset.
module tb_fetch_prefetch_ctrl;
  typedef struct {
    logic        fe;
    logic        rdy;
    logic        redir;
    logic [31:0] rpc;
    logic        ev;
    logic [31:0] epc;
    logic [2:0]  ecnt;
    logic [31:0] eaddr;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;
  vec_t vq[$];

  fetch_prefetch_ctrl_if #(.DEPTH(4)) if_i ();

  fetch_prefetch_ctrl #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (if_i)
  );

  assign if_i.mem_data = if_i.mem_addr;

  always #5 clk = ~clk;

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s step %0d: got %h, expected %h", name, idx, act, exp);
    end
  endtask

  task automatic add(input logic fe, input logic rdy, input logic redir, input logic [31:0] rpc,
                     input logic ev, input logic [31:0] epc, input logic [2:0] ecnt, input logic [31:0] eaddr);
    vec_t v;
    v.fe = fe; v.rdy = rdy; v.redir = redir; v.rpc = rpc;
    v.ev = ev; v.epc = epc; v.ecnt = ecnt; v.eaddr = eaddr;
    vq.push_back(v);
  endtask

  task automatic check_out(input string tag, input int idx, input logic ev, input logic [31:0] epc,
                           input logic [2:0] ecnt, input logic [31:0] eaddr);
    $display("%s %0d: valid=%0b pc=%h instr=%h cnt=%0d addr=%h", tag, idx,
             if_i.out_valid, if_i.out_pc, if_i.out_instr, if_i.q_count, if_i.mem_addr);
    chk("out_valid", idx, {31'd0, if_i.out_valid}, {31'd0, ev});
    chk("q_count",   idx, {29'd0, if_i.q_count},   {29'd0, ecnt});
    chk("mem_addr",  idx, if_i.mem_addr, eaddr);
    if (ev) begin
      chk("out_pc",    idx, if_i.out_pc,    epc);
      chk("out_instr", idx, if_i.out_instr, epc);
    end
  endtask

  initial begin
    // fe rdy redir rpc | valid pc cnt addr
    add(1,1,0,0, 0,32'h0,  0,32'h0);
    add(1,1,0,0, 1,32'h0,  1,32'h4);
    add(1,1,0,0, 1,32'h4,  1,32'h8);
    add(1,0,0,0, 1,32'h8,  1,32'hC);   // stall: queue fills
    add(1,0,0,0, 1,32'h8,  2,32'h10);
    add(1,0,0,0, 1,32'h8,  3,32'h14);
    add(1,0,0,0, 1,32'h8,  4,32'h18);
    add(1,0,0,0, 1,32'h8,  4,32'h18);
    add(1,1,0,0, 1,32'h8,  4,32'h18);  // release: no gap
    add(1,1,0,0, 1,32'hC,  4,32'h1C);
    add(1,1,0,0, 1,32'h10, 4,32'h20);
    add(0,1,0,0, 1,32'h14, 4,32'h24);  // drain one -> 3 entries
    add(1,1,1,32'hD8, 0,32'h0, 3,32'h24);
    add(1,1,0,0, 0,32'h0,  0,32'hD8);
    add(1,1,0,0, 1,32'hD8, 1,32'hDC);
    add(1,1,0,0, 1,32'hDC, 1,32'hE0);
    add(1,1,1,32'h103, 0,32'h0, 1,32'hE4);
    add(1,1,0,0, 0,32'h0,  0,32'h100);
    add(1,1,0,0, 1,32'h100,1,32'h104);
    add(1,1,1,32'hFFFF_FFFC, 0,32'h0, 1,32'h108);
    add(1,1,0,0, 0,32'h0,  0,32'hFFFF_FFFC);
    add(1,1,0,0, 1,32'hFFFF_FFFC, 1,32'h0);
    add(1,1,0,0, 1,32'h0,  1,32'h4);
    add(1,0,0,0, 1,32'h4,  1,32'h8);   // build 2 entries
    add(0,1,0,0, 1,32'h4,  2,32'hC);   // fetch disabled: drain
    add(0,1,0,0, 1,32'h8,  1,32'hC);
    add(0,1,0,0, 0,32'h0,  0,32'hC);
    add(0,1,0,0, 0,32'h0,  0,32'hC);
    add(1,1,0,0, 0,32'h0,  0,32'hC);
    add(1,1,0,0, 1,32'hC,  1,32'h10);
    add(1,0,0,0, 1,32'h10, 1,32'h14);
    add(1,0,0,0, 1,32'h10, 2,32'h18);
    add(1,0,0,0, 1,32'h10, 3,32'h1C);
    add(1,0,0,0, 1,32'h10, 4,32'h20);
    add(1,1,1,32'h40, 0,32'h0, 4,32'h20); // redirect while full
    add(1,1,0,0, 0,32'h0,  0,32'h40);
    add(1,1,0,0, 1,32'h40, 1,32'h44);

    reset = 1'b1;
    if_i.fetch_en = 1'b1; if_i.out_ready = 1'b1; if_i.redirect = 1'b0; if_i.redirect_pc = '0;
    #1;
    check_out("reset", 0, 1'b0, 32'h0, 3'd0, 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < vq.size(); i++) begin
      if_i.fetch_en    = vq[i].fe;
      if_i.out_ready   = vq[i].rdy;
      if_i.redirect    = vq[i].redir;
      if_i.redirect_pc = vq[i].rpc;
      #1;
      check_out("vec", i, vq[i].ev, vq[i].epc, vq[i].ecnt, vq[i].eaddr);
      @(negedge clk);
    end

    // Fill the queue, then assert reset between clock edges.
    if_i.fetch_en = 1'b1; if_i.out_ready = 1'b0; if_i.redirect = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    check_out("full", 100, 1'b1, 32'h44, 3'd4, 32'h54);
    #1;
    reset = 1'b1;
    #1;
    check_out("async_rst", 101, 1'b0, 32'h0, 3'd0, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    if_i.out_ready = 1'b1;
    #1;
    check_out("restart", 102, 1'b0, 32'h0, 3'd0, 32'h0);
    @(negedge clk); #1;
    check_out("restart", 103, 1'b1, 32'h0, 3'd1, 32'h4);
    @(negedge clk); #1;
    check_out("restart", 104, 1'b1, 32'h4, 3'd1, 32'h8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
